// File: rtl/llr_phase_former_if.sv
// llr_phase_former_if: sample/LLR handshake bundle for llr_phase_former
//   i_vld/o_rdy/i_i/i_q           input sample stream
//   i_next_phase/i_llr_reset      phase-control pulses from the sync system
//   o_vld/i_rdy/o_llr0/o_llr1     output LLR stream
//   o_last_phase_stb/o_phase      last-phase strobe and debug phase
interface llr_phase_former_if #(
    parameter int IQ_WIDTH  = 8,
    parameter int LLR_WIDTH = 4
);
    logic                        i_vld;
    logic                        o_rdy;
    logic signed [IQ_WIDTH-1:0]  i_i;
    logic signed [IQ_WIDTH-1:0]  i_q;
    logic                        i_next_phase;
    logic                        i_llr_reset;
    logic                        o_vld;
    logic                        i_rdy;
    logic signed [LLR_WIDTH-1:0] o_llr0;
    logic signed [LLR_WIDTH-1:0] o_llr1;
    logic                        o_last_phase_stb;
    logic [2:0]                  o_phase;
    modport slave (
        input  i_vld, i_i, i_q, i_next_phase, i_llr_reset, i_rdy,
        output o_rdy, o_vld, o_llr0, o_llr1, o_last_phase_stb, o_phase
    );
    modport master (
        output i_vld, i_i, i_q, i_next_phase, i_llr_reset, i_rdy,
        input  o_rdy, o_vld, o_llr0, o_llr1, o_last_phase_stb, o_phase
    );
endinterface

// File: rtl/llr_phase_former.sv
// llr_phase_former: rotates each QPSK I/Q sample by the phase hypothesis, then scales and saturates it to an LLR pair
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      llr_phase_former_if.slave: sample in, LLR pair out, phase control, strobe, debug phase
module llr_phase_former #(
    parameter int IQ_WIDTH    = 8,
    parameter int LLR_WIDTH   = 4,
    parameter int SCALE_SHIFT = 2,
    parameter int NUM_PHASES  = 8
) (
    input logic               clk,
    input logic               reset_n,
    llr_phase_former_if.slave bus
);
    localparam logic [2:0] LAST = 3'(NUM_PHASES - 1);
    localparam logic [2:0] PRE  = 3'(NUM_PHASES - 2);
    localparam logic signed [IQ_WIDTH-1:0] IQ_MIN  = {1'b1, {(IQ_WIDTH-1){1'b0}}};
    localparam logic signed [IQ_WIDTH-1:0] IQ_MAX  = ~IQ_MIN;
    localparam logic signed [IQ_WIDTH-1:0] LLR_MAX = IQ_WIDTH'((1 << (LLR_WIDTH - 1)) - 1);
    localparam logic signed [IQ_WIDTH-1:0] LLR_MIN = -LLR_MAX;

    generate
        if (NUM_PHASES != 4 && NUM_PHASES != 8) begin : g_bad_phases
            $error("llr_phase_former: NUM_PHASES must be 4 or 8");
        end
    endgenerate

    // Negation that maps the most-negative code to the most-positive one
    function automatic logic signed [IQ_WIDTH-1:0] neg(input logic signed [IQ_WIDTH-1:0] x);
        return (x == IQ_MIN) ? IQ_MAX : -x;
    endfunction

    // Symmetric saturation keeps the most-negative LLR code out of the stream
    function automatic logic signed [LLR_WIDTH-1:0] sat(input logic signed [IQ_WIDTH-1:0] x);
        logic signed [IQ_WIDTH-1:0] s;
        s = x >>> SCALE_SHIFT;
        return (s > LLR_MAX) ? LLR_MAX[LLR_WIDTH-1:0] :
               (s < LLR_MIN) ? LLR_MIN[LLR_WIDTH-1:0] : s[LLR_WIDTH-1:0];
    endfunction

    logic [2:0]                  phase;
    logic                        entered;
    logic                        stb;
    logic                        rdy_en;
    logic                        s1_vld;
    logic signed [IQ_WIDTH-1:0]  s1_a;
    logic signed [IQ_WIDTH-1:0]  s1_b;
    logic                        s2_vld;
    logic signed [LLR_WIDTH-1:0] s2_l0;
    logic signed [LLR_WIDTH-1:0] s2_l1;
    logic signed [IQ_WIDTH-1:0]  ra;
    logic signed [IQ_WIDTH-1:0]  rb;
    logic                        swap;
    logic                        s2_en;
    logic                        s2_adv;
    logic                        rdy;

    always_comb begin
        ra   = (phase[1:0] == 2'd0) ? bus.i_i      :
               (phase[1:0] == 2'd1) ? neg(bus.i_q) :
               (phase[1:0] == 2'd2) ? neg(bus.i_i) : bus.i_q;
        rb   = (phase[1:0] == 2'd0) ? bus.i_q      :
               (phase[1:0] == 2'd1) ? bus.i_i      :
               (phase[1:0] == 2'd2) ? neg(bus.i_q) : neg(bus.i_i);
        swap = (NUM_PHASES == 8) && phase[2];
    end

    assign s2_en  = !s2_vld || bus.i_rdy;
    assign s2_adv = s1_vld && s2_en;
    // rdy_en holds o_rdy low until the first clock after reset release
    assign rdy    = rdy_en && (!s1_vld || s2_adv);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= 3'd0;
            entered <= 1'b0;
            stb     <= 1'b0;
            rdy_en  <= 1'b0;
            s1_vld  <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s2_vld  <= 1'b0;
            s2_l0   <= '0;
            s2_l1   <= '0;
        end else begin
            rdy_en  <= 1'b1;
            phase   <= bus.i_llr_reset  ? 3'd0 :
                       bus.i_next_phase ? ((phase == LAST) ? 3'd0 : phase + 3'd1) : phase;
            // entered marks the edge that lands on the last phase; the strobe follows one cycle later
            entered <= bus.i_next_phase && !bus.i_llr_reset && (phase == PRE);
            stb     <= entered;
            if (rdy) begin
                s1_vld <= bus.i_vld;
            end
            if (rdy && bus.i_vld) begin
                s1_a <= swap ? rb : ra;
                s1_b <= swap ? ra : rb;
            end
            if (s2_en) begin
                s2_vld <= s1_vld;
            end
            if (s2_adv) begin
                s2_l0 <= sat(s1_a);
                s2_l1 <= sat(s1_b);
            end
        end
    end

    assign bus.o_rdy            = rdy;
    assign bus.o_vld            = s2_vld;
    assign bus.o_llr0           = s2_l0;
    assign bus.o_llr1           = s2_l1;
    assign bus.o_last_phase_stb = stb;
    assign bus.o_phase          = phase;
endmodule

// File: tb/tb_llr_phase_former.sv
// tb_llr_phase_former: directed self-checking bench for llr_phase_former with a per-cycle reference model
module tb_llr_phase_former;
    logic clk;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;
    int   out_cnt = 0;
    int   stb_cnt = 0;

    llr_phase_former_if #(.IQ_WIDTH(8), .LLR_WIDTH(4)) bus ();

    llr_phase_former #(.IQ_WIDTH(8), .LLR_WIDTH(4), .SCALE_SHIFT(2), .NUM_PHASES(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nsat(input int x);
        return (x == -128) ? 127 : -x;
    endfunction

    function automatic int scl(input int x);
        int s;
        s = x >>> 2;
        return (s > 7) ? 7 : (s < -7) ? -7 : s;
    endfunction

    // Reference: rotation table by phase mod 4, swap for phases 4..7, then scale and clamp
    function automatic void model(input int i, input int q, input int ph, output int l0, output int l1);
        int a;
        int b;
        int t;
        case (ph % 4)
            0:       begin a = i;       b = q;       end
            1:       begin a = nsat(q); b = i;       end
            2:       begin a = nsat(i); b = nsat(q); end
            default: begin a = q;       b = nsat(i); end
        endcase
        if (ph >= 4) begin
            t = a;
            a = b;
            b = t;
        end
        l0 = scl(a);
        l1 = scl(b);
    endfunction

    typedef struct {
        int l0;
        int l1;
        int t;
    } item_t;

    item_t q[$];
    int    pm = 0;
    bit    started = 0;
    int    cyc = 0;
    int    stb_cyc = -10;
    bit    prev_stall = 0;
    int    prev_l0 = 0;
    int    prev_l1 = 0;

    always @(negedge clk) begin
        item_t it;
        bit    ev;
        bit    er;
        if (!reset_n) begin
            chk("rst_vld", int'(bus.o_vld), 0);
            chk("rst_rdy", int'(bus.o_rdy), 0);
            chk("rst_phase", int'(bus.o_phase), 0);
            chk("rst_stb", int'(bus.o_last_phase_stb), 0);
            chk("rst_llr0", int'(bus.o_llr0), 0);
            chk("rst_llr1", int'(bus.o_llr1), 0);
            q.delete();
            pm = 0;
            started = 0;
            stb_cyc = -10;
            prev_stall = 0;
        end else begin
            ev = (q.size() > 0) && (cyc >= q[0].t + 2);
            er = started && !(q.size() == 2 && !bus.i_rdy);
            chk("vld", int'(bus.o_vld), int'(ev));
            chk("rdy", int'(bus.o_rdy), int'(er));
            chk("phase", int'(bus.o_phase), pm);
            chk("stb", int'(bus.o_last_phase_stb), int'(cyc == stb_cyc));
            if (ev) begin
                chk("llr0", int'(bus.o_llr0), q[0].l0);
                chk("llr1", int'(bus.o_llr1), q[0].l1);
            end
            if (prev_stall) begin
                chk("stall_vld", int'(bus.o_vld), 1);
                chk("stall_llr0", int'(bus.o_llr0), prev_l0);
                chk("stall_llr1", int'(bus.o_llr1), prev_l1);
            end
            prev_stall = bus.o_vld && !bus.i_rdy;
            prev_l0 = int'(bus.o_llr0);
            prev_l1 = int'(bus.o_llr1);
            if (bus.o_last_phase_stb) stb_cnt++;
            if (ev && bus.i_rdy) begin
                void'(q.pop_front());
                out_cnt++;
            end
            if (bus.i_vld && er) begin
                model(int'(bus.i_i), int'(bus.i_q), pm, it.l0, it.l1);
                it.t = cyc;
                q.push_back(it);
            end
            if (bus.i_llr_reset) begin
                pm = 0;
            end else if (bus.i_next_phase) begin
                pm = (pm == 7) ? 0 : pm + 1;
                if (pm == 7) stb_cyc = cyc + 2;
            end
            started = 1;
        end
        cyc++;
    end

    task automatic run_one(input int ii, input int qq, input int e0, input int e1, input string nm);
        int lat;
        @(posedge clk); #1;
        bus.i_vld = 1'b1;
        bus.i_i = 8'(ii);
        bus.i_q = 8'(qq);
        @(posedge clk); #1;
        bus.i_vld = 1'b0;
        lat = 1;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            if (bus.o_vld) break;
            lat++;
        end
        chk({nm, "_lat"}, lat, 2);
        chk({nm, "_llr0"}, int'(bus.o_llr0), e0);
        chk({nm, "_llr1"}, int'(bus.o_llr1), e1);
    endtask

    task automatic pulse_next(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.i_next_phase = 1'b1;
        end
        @(posedge clk); #1;
        bus.i_next_phase = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        bus.i_llr_reset = 1'b1;
        @(posedge clk); #1;
        bus.i_llr_reset = 1'b0;
    endtask

    int         ti[16] = '{40, -20, 127, -128, 0, 5, -5, 33, -64, 100, -100, 7, -8, 64, 12, -1};
    int         tq[16] = '{-20, 40, -128, 127, -7, 9, -33, 0, 64, -100, 28, 3, -128, -64, 99, 1};
    logic [31:0] rp = 32'b1011_0010_1110_0101_1100_1011_0110_1001;

    initial begin
        int base;
        int s0;
        int k;
        int c;
        reset_n = 1'b0;
        bus.i_vld = 1'b0;
        bus.i_i = '0;
        bus.i_q = '0;
        bus.i_next_phase = 1'b0;
        bus.i_llr_reset = 1'b0;
        bus.i_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;

        run_one(40, -20, 7, -5, "t1");
        pulse_next(1);
        run_one(40, -20, 5, 7, "t2a");
        pulse_next(2);
        run_one(40, -20, -5, -7, "t2b");
        pulse_reset();
        pulse_next(2);
        run_one(-128, 0, 7, 0, "t3");

        pulse_reset();
        s0 = stb_cnt;
        pulse_next(7);
        chk("t4_phase7", int'(bus.o_phase), 7);
        repeat (3) @(posedge clk);
        chk("t4_stb_once", stb_cnt - s0, 1);
        pulse_next(1);
        chk("t4_wrap", int'(bus.o_phase), 0);
        repeat (3) @(posedge clk);
        chk("t4_no_stb_wrap", stb_cnt - s0, 1);
        pulse_next(5);
        chk("t4_phase5", int'(bus.o_phase), 5);
        @(posedge clk); #1;
        bus.i_next_phase = 1'b1;
        bus.i_llr_reset = 1'b1;
        @(posedge clk); #1;
        bus.i_next_phase = 1'b0;
        bus.i_llr_reset = 1'b0;
        chk("t4_both", int'(bus.o_phase), 0);
        repeat (3) @(posedge clk);
        chk("t4_no_stb_both", stb_cnt - s0, 1);

        base = out_cnt;
        k = 0;
        c = 0;
        while (k < 16 && c < 200) begin
            @(posedge clk); #1;
            bus.i_vld = 1'b1;
            bus.i_i = 8'(ti[k]);
            bus.i_q = 8'(tq[k]);
            bus.i_rdy = rp[c % 32];
            bus.i_next_phase = (c == 6 || c == 14);
            @(negedge clk);
            if (bus.o_rdy) k++;
            c++;
        end
        @(posedge clk); #1;
        bus.i_vld = 1'b0;
        bus.i_next_phase = 1'b0;
        bus.i_rdy = 1'b1;
        for (int w = 0; w < 40 && out_cnt < base + 16; w++) @(negedge clk);
        chk("t5_count", out_cnt - base, 16);

        @(posedge clk); #1;
        bus.i_rdy = 1'b0;
        bus.i_vld = 1'b1;
        bus.i_i = 8'sd40;
        bus.i_q = -8'sd20;
        bus.i_next_phase = 1'b1;
        @(posedge clk); #1;
        bus.i_i = 8'sd12;
        bus.i_next_phase = 1'b0;
        @(posedge clk); #1;
        bus.i_vld = 1'b0;
        chk("t6_full_rdy", int'(bus.o_rdy), 0);
        chk("t6_full_vld", int'(bus.o_vld), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_vld", int'(bus.o_vld), 0);
        chk("t6_async_phase", int'(bus.o_phase), 0);
        chk("t6_async_rdy", int'(bus.o_rdy), 0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        bus.i_rdy = 1'b1;
        @(posedge clk); #1;
        chk("t6_rdy_after", int'(bus.o_rdy), 1);
        run_one(40, -20, 7, -5, "t6");
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
